// File: rtl/vfu_wb_arbiter.sv
// Per-lane VRF write-port arbiter: round-robin between the vector ALU and the
// MFPU, with a single-entry registered output stage toward the VRF.
module vfu_wb_arbiter #(
  parameter int unsigned NrVInsn   = 8,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned AddrWidth = 10,
  localparam int unsigned VidW     = $clog2(NrVInsn),
  localparam int unsigned StrbW    = DataWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 alu_req_i,
  input  logic [VidW-1:0]      alu_id_i,
  input  logic [AddrWidth-1:0] alu_addr_i,
  input  logic [DataWidth-1:0] alu_wdata_i,
  input  logic [StrbW-1:0]     alu_be_i,
  output logic                 alu_gnt_o,
  input  logic                 mfpu_req_i,
  input  logic [VidW-1:0]      mfpu_id_i,
  input  logic [AddrWidth-1:0] mfpu_addr_i,
  input  logic [DataWidth-1:0] mfpu_wdata_i,
  input  logic [StrbW-1:0]     mfpu_be_i,
  output logic                 mfpu_gnt_o,
  output logic                 vrf_req_o,
  output logic [VidW-1:0]      vrf_id_o,
  output logic [AddrWidth-1:0] vrf_addr_o,
  output logic [DataWidth-1:0] vrf_wdata_o,
  output logic [StrbW-1:0]     vrf_be_o,
  input  logic                 vrf_gnt_i,
  output logic [NrVInsn-1:0]   wb_pending_o
);

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_e;
  typedef enum logic {RR_ALU = 1'b0, RR_MFPU = 1'b1} rr_e;

  state_e               state_q, state_d;
  rr_e                  rr_q, rr_d;
  logic [VidW-1:0]      id_q, id_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic [StrbW-1:0]     be_q, be_d;
  logic [NrVInsn-1:0]   wb_pending_q, wb_pending_d;

  logic can_load_s;
  logic alu_gnt_s;
  logic mfpu_gnt_s;

  // Arbitration: on a tie the requester that did not win last time is granted.
  always_comb begin
    can_load_s = 1'b0;
    alu_gnt_s  = 1'b0;
    mfpu_gnt_s = 1'b0;
    case (state_q)
      ST_EMPTY: can_load_s = 1'b1;
      ST_FULL:  can_load_s = vrf_gnt_i;
      default:  can_load_s = 1'b0;
    endcase
    if (!rst_i && can_load_s) begin
      if (alu_req_i && mfpu_req_i) begin
        if (rr_q == RR_ALU) begin
          mfpu_gnt_s = 1'b1;
        end else begin
          alu_gnt_s = 1'b1;
        end
      end else begin
        alu_gnt_s  = alu_req_i;
        mfpu_gnt_s = mfpu_req_i;
      end
    end else begin
      alu_gnt_s  = 1'b0;
      mfpu_gnt_s = 1'b0;
    end
  end

  // Output-stage next state: load on grant, drain on VRF accept, else hold.
  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    id_d         = id_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    wb_pending_d = {NrVInsn{1'b0}};
    if (alu_gnt_s) begin
      state_d = ST_FULL;
      rr_d    = RR_ALU;
      id_d    = alu_id_i;
      addr_d  = alu_addr_i;
      wdata_d = alu_wdata_i;
      be_d    = alu_be_i;
    end else if (mfpu_gnt_s) begin
      state_d = ST_FULL;
      rr_d    = RR_MFPU;
      id_d    = mfpu_id_i;
      addr_d  = mfpu_addr_i;
      wdata_d = mfpu_wdata_i;
      be_d    = mfpu_be_i;
    end else if (state_q == ST_FULL && vrf_gnt_i) begin
      state_d = ST_EMPTY;
    end else begin
      state_d = state_q;
    end
    // Hazard vector is precomputed so the lane sequencer sees a flop output.
    if (state_d == ST_FULL) begin
      wb_pending_d[id_d] = 1'b1;
    end else begin
      wb_pending_d = {NrVInsn{1'b0}};
    end
  end

  // State and payload registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_EMPTY;
      rr_q         <= RR_ALU;
      id_q         <= {VidW{1'b0}};
      addr_q       <= {AddrWidth{1'b0}};
      wdata_q      <= {DataWidth{1'b0}};
      be_q         <= {StrbW{1'b0}};
      wb_pending_q <= {NrVInsn{1'b0}};
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      id_q         <= id_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      wb_pending_q <= wb_pending_d;
    end
  end

  assign alu_gnt_o    = alu_gnt_s;
  assign mfpu_gnt_o   = mfpu_gnt_s;
  assign vrf_req_o    = (state_q == ST_FULL);
  assign vrf_id_o     = id_q;
  assign vrf_addr_o   = addr_q;
  assign vrf_wdata_o  = wdata_q;
  assign vrf_be_o     = be_q;
  assign wb_pending_o = wb_pending_q;

endmodule

// File: doc/vfu_wb_arbiter.md
Name: vfu_wb_arbiter

Overview:
- Shares one VRF write port per lane between the vector ALU and the Multiplier/FPU result interfaces.
- Sits between the lane's functional-unit stage and the VRF.
- Round-robin arbitration plus a single-entry registered output stage, so FU-to-VRF timing is cut.
- Exports a per-instruction "write in flight" vector for hazard tracking in the lane sequencer.

Parameters:
- NrVInsn, 8, number of in-flight vector instruction IDs. vid width VidW = clog2(NrVInsn).
- DataWidth, 64, element word width (ELEN). Strobe width StrbW = DataWidth/8.
- AddrWidth, 10, VRF word address width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- alu_req_i  in  1  ALU write request.
- alu_id_i  in  VidW  ALU instruction ID.
- alu_addr_i  in  AddrWidth  ALU VRF address.
- alu_wdata_i  in  DataWidth  ALU write data.
- alu_be_i  in  StrbW  ALU byte enables.
- alu_gnt_o  out  1  ALU request accepted.
- mfpu_req_i, mfpu_id_i, mfpu_addr_i, mfpu_wdata_i, mfpu_be_i, mfpu_gnt_o: same set as the ALU ports, for the MFPU.
- vrf_req_o  out  1  write request to the VRF.
- vrf_id_o  out  VidW  ID of the held write.
- vrf_addr_o  out  AddrWidth  address of the held write.
- vrf_wdata_o  out  DataWidth  data of the held write.
- vrf_be_o  out  StrbW  byte enables of the held write.
- vrf_gnt_i  in  1  VRF accepted the held write.
- wb_pending_o  out  NrVInsn  one-hot of the vid held in the output register.

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is synchronous and active-high.
- Reset values:
  - vrf_req_o = 0; vrf_id/addr/wdata/be_o = 0.
  - alu_gnt_o = mfpu_gnt_o = 0; wb_pending_o = 0.
  - Round-robin pointer rr = ALU, i.e. MFPU has priority in the first conflict.
- Requester handshake:
  - A requester raises req and holds req/id/addr/wdata/be stable until the cycle its gnt is high.
  - gnt is a single-cycle pulse. That cycle is the transfer.
- Output register:
  - A single entry with states EMPTY and FULL. vrf_req_o = FULL.
  - Its contents drive vrf_*_o directly; no combinational path exists from inputs to vrf_*_o.
- Accept condition: can_load = EMPTY | (FULL & vrf_gnt_i).
- Arbitration, evaluated combinationally each cycle when can_load:
  - Exactly one requester active: grant it.
  - Both active: grant the requester that is not rr.
  - After each grant, rr <= the granted requester.
  - gnt_o is asserted in the same cycle, and the request is loaded at the clock edge, so latency is 1 cycle from req to vrf_req_o.
- Transitions:
  - EMPTY -> FULL on a grant.
  - FULL & vrf_gnt_i with a grant: stays FULL and loads the new entry (back-to-back, one write per cycle sustained).
  - FULL & vrf_gnt_i without a grant -> EMPTY.
  - FULL & !vrf_gnt_i: hold the entry. Both gnt_o are 0 (backpressure).
- At most one of alu_gnt_o / mfpu_gnt_o is high per cycle.
- wb_pending_o[vid] = FULL & (vrf_id_o == vid); all zeros when EMPTY. It is driven from registered state only.
- vrf_gnt_i while EMPTY is ignored.
- Reset asserted mid-operation drops the held write (EMPTY, rr = ALU) and produces no gnt in that cycle. Requesters are reset in the same cycle.
- The arbiter does not check data or IDs. Duplicate IDs from both FUs are forwarded in arbitration order.

Test Plan:
- Reset: hold rst_i 2 cycles with both req=1 -> vrf_req_o=0, both gnt=0, wb_pending_o=0. On the first cycle after release, mfpu_gnt_o=1 (rr=ALU at reset).
- Single ALU stream: alu_req held for 4 writes (addr 0x10..0x13), vrf_gnt_i=1 always -> alu_gnt_o high 4 consecutive cycles. vrf_addr_o shows 0x10..0x13 one cycle later, back-to-back, no bubbles.
- Contention: both req held continuously, vrf_gnt_i=1 -> grants alternate MFPU, ALU, MFPU, ALU. vrf_id_o alternates mfpu_id (5) and alu_id (2).
- Backpressure: FULL with addr 0x20; vrf_gnt_i=0 for 3 cycles -> vrf_*_o stable, both gnt=0, wb_pending_o=8'b0000_0100 for vid 2. Once vrf_gnt_i=1, the pending requester is granted that same cycle.
- Drain: single write, then no requests, vrf_gnt_i=1 -> vrf_req_o deasserts the next cycle and wb_pending_o=0. A spurious vrf_gnt_i while EMPTY has no effect.
- Mid-operation reset: FULL, vrf_gnt_i=0, rst_i pulsed -> next cycle vrf_req_o=0, wb_pending_o=0. The following arbitration favours MFPU.
